// File: rtl/otter_mdu.sv
// rtl/otter_mdu.sv - RV32M multi-cycle multiply/divide unit for the OTTER execute stage
//
// Ports:
//   CLK      in   clock, all state changes on the rising edge
//   RST      in   synchronous active-high reset
//   START    in   request strobe, only acted on in IDLE
//   A, B     in   operands (multiplicand/dividend, multiplier/divisor)
//   MDU_FUN  in   0 MUL 1 MULH 2 MULHSU 3 MULHU 4 DIV 5 DIVU 6 REM 7 REMU
//   BUSY     out  high while iterating (CALC) and correcting (FIX)
//   DONE     out  one-cycle pulse, RESULT valid
//   RESULT   out  result, stable from DONE until the next accepted START
//
// Optional feature: define MDU_EARLY_OUT_EN to finish multiplies with a zero
// operand in one cycle; results are identical, only latency changes.

module otter_mdu #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       MDU_FUN,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] RESULT
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    state_t state, state_next;

    // Shared iteration register: product for multiplies,
    // {partial remainder, quotient} for divides.
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   mcand;     // |A| for multiply, |B| for divide
    logic [2:0]         fun_q;
    logic               neg_q;     // product / quotient sign
    logic               rneg_q;    // remainder sign
    logic [CW-1:0]      cnt;

    // Operand decode, used only at acceptance in IDLE
    logic               is_div_in;
    logic               a_signed_in, b_signed_in;
    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic               special;
    logic [WIDTH-1:0]   special_res;

    // Iteration and correction datapath
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_shift;
    logic               div_ge;
    logic [WIDTH-1:0]   div_diff;
    logic [2*WIDTH-1:0] div_next;
    logic [2*WIDTH-1:0] mul_p;
    logic [WIDTH-1:0]   q_fix, r_fix;
    logic [WIDTH-1:0]   fix_res;

    always_comb begin
        is_div_in   = MDU_FUN[2];
        // Divides: even codes signed. Multiplies: A signed except MULHU,
        // B signed only for MUL/MULH.
        a_signed_in = is_div_in ? ~MDU_FUN[0] : (MDU_FUN != 3'd3);
        b_signed_in = is_div_in ? ~MDU_FUN[0] : ~MDU_FUN[1];
        a_neg       = a_signed_in & A[WIDTH-1];
        b_neg       = b_signed_in & B[WIDTH-1];
        // Most-negative negates to itself, which is the correct unsigned magnitude.
        a_mag       = a_neg ? -A : A;
        b_mag       = b_neg ? -B : B;
    end

    always_comb begin
        special     = 1'b0;
        special_res = '0;
        if (is_div_in && (B == '0)) begin
            special     = 1'b1;
            special_res = MDU_FUN[1] ? A : '1;
        end else if (is_div_in && !MDU_FUN[0] &&
                     (A == {1'b1, {(WIDTH-1){1'b0}}}) && (B == '1)) begin
            special     = 1'b1;
            special_res = MDU_FUN[1] ? '0 : A;
        end
`ifdef MDU_EARLY_OUT_EN
        else if (!is_div_in && ((A == '0) || (B == '0))) begin
            special     = 1'b1;
            special_res = '0;
        end
`else
`endif
    end

    always_comb begin
        // Shift-add: add multiplicand into the upper half when the current
        // multiplier bit (LSB) is set, then shift the whole product right.
        mul_sum   = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : '0);
        mul_next  = {mul_sum, prod[WIDTH-1:1]};

        // Restoring step: shift next dividend bit into the remainder and
        // subtract the divisor if it fits. The difference is smaller than the
        // divisor when kept, so its low WIDTH bits are exact.
        div_shift = prod[2*WIDTH-1:WIDTH-1];
        div_ge    = (div_shift >= {1'b0, mcand});
        div_diff  = div_shift[WIDTH-1:0] - mcand;
        div_next  = {(div_ge ? div_diff : div_shift[WIDTH-1:0]), prod[WIDTH-2:0], div_ge};
    end

    always_comb begin
        mul_p   = neg_q ? -prod : prod;
        q_fix   = neg_q ? -prod[WIDTH-1:0] : prod[WIDTH-1:0];
        r_fix   = rneg_q ? -prod[2*WIDTH-1:WIDTH] : prod[2*WIDTH-1:WIDTH];
        fix_res = '0;
        case (fun_q)
            3'd0:             fix_res = mul_p[WIDTH-1:0];
            3'd1, 3'd2, 3'd3: fix_res = mul_p[2*WIDTH-1:WIDTH];
            3'd4, 3'd5:       fix_res = q_fix;
            default:          fix_res = r_fix;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        BUSY       = 1'b0;
        DONE       = 1'b0;
        case (state)
            S_IDLE: begin
                if (START) begin
                    state_next = special ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                BUSY = 1'b1;
                if (cnt == '0) begin
                    state_next = S_FIX;
                end
            end
            S_FIX: begin
                BUSY       = 1'b1;
                state_next = S_DONE;
            end
            S_DONE: begin
                DONE       = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            prod   <= '0;
            mcand  <= '0;
            fun_q  <= '0;
            neg_q  <= 1'b0;
            rneg_q <= 1'b0;
            cnt    <= '0;
            RESULT <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (START) begin
                        fun_q  <= MDU_FUN;
                        neg_q  <= a_neg ^ b_neg;
                        rneg_q <= a_neg;
                        cnt    <= CW'(WIDTH-1);
                        prod   <= {{WIDTH{1'b0}}, (is_div_in ? a_mag : b_mag)};
                        mcand  <= is_div_in ? b_mag : a_mag;
                        if (special) begin
                            RESULT <= special_res;
                        end
                    end
                end
                S_CALC: begin
                    cnt  <= cnt - CW'(1);
                    prod <= fun_q[2] ? div_next : mul_next;
                end
                S_FIX: begin
                    RESULT <= fix_res;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_otter_mdu.sv
// tb/tb_otter_mdu.sv - self-checking bench for otter_mdu (WIDTH=32)

module tb_otter_mdu;

    logic        CLK = 1'b0;
    logic        RST;
    logic        START;
    logic [31:0] A;
    logic [31:0] B;
    logic [2:0]  MDU_FUN;
    logic        BUSY;
    logic        DONE;
    logic [31:0] RESULT;

    int total   = 0;
    int passed  = 0;
    int overlap = 0;

    otter_mdu #(.WIDTH(32)) dut (
        .CLK(CLK),
        .RST(RST),
        .START(START),
        .A(A),
        .B(B),
        .MDU_FUN(MDU_FUN),
        .BUSY(BUSY),
        .DONE(DONE),
        .RESULT(RESULT)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (BUSY && DONE) overlap++;
    end

    typedef struct {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, ua, ub;
        logic [63:0] p;
        int          ia, ib;
        logic [31:0] r;
        logic        ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = longint'({32'd0, a});
        ub  = longint'({32'd0, b});
        ia  = $signed(a);
        ib  = $signed(b);
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        p   = '0;
        r   = '0;
        case (f)
            3'd0: begin p = ua * ub; r = p[31:0];  end
            3'd1: begin p = sa * sb; r = p[63:32]; end
            3'd2: begin p = sa * ub; r = p[63:32]; end
            3'd3: begin p = ua * ub; r = p[63:32]; end
            3'd4: r = (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'(ia / ib);
            3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: r = (b == 0) ? a : ovf ? 32'd0 : 32'(ia % ib);
            default: r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    function automatic int model_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (f[2] && b == 0) return 1;
        if (!f[0] && f[2] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`ifdef MDU_EARLY_OUT_EN
        if (!f[2] && (a == 0 || b == 0)) return 1;
`endif
        return 34;
    endfunction

    // Issues one request; lat counts cycles from the START sampling edge to
    // DONE (-1 on timeout); busy1 is BUSY in the first cycle after acceptance.
    task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int lat, output logic busy1);
        @(negedge CLK);
        START = 1'b1; A = a; B = b; MDU_FUN = f;
        @(negedge CLK);
        START = 1'b0;
        busy1 = BUSY;
        lat = -1;
        for (int k = 1; k <= 100; k++) begin
            if (DONE) begin
                lat = k;
                break;
            end
            @(negedge CLK);
        end
        res = RESULT;
    endtask

    initial begin
        logic [31:0] res;
        int          lat;
        logic        busy1;
        int          seen;

        RST = 1'b1; START = 1'b0; A = '0; B = '0; MDU_FUN = '0;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        chk("reset BUSY", 32'(BUSY), 32'd0);
        chk("reset DONE", 32'(DONE), 32'd0);
        chk("reset RESULT", RESULT, 32'd0);

        vecs.push_back('{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 34});
        vecs.push_back('{3'd1, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFFF, 34});
        vecs.push_back('{3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 34});
        vecs.push_back('{3'd3, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 34});
        vecs.push_back('{3'd2, 32'h8000_0000,  32'h8000_0000, 32'hC000_0000, 34});
        vecs.push_back('{3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 34});
        vecs.push_back('{3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 34});
        vecs.push_back('{3'd5, 32'hFFFF_FFF9,  32'd2,         32'h7FFF_FFFC, 34});
        vecs.push_back('{3'd5, 32'h0000_1234,  32'd0,         32'hFFFF_FFFF, 1});
        vecs.push_back('{3'd7, 32'h0000_1234,  32'd0,         32'h0000_1234, 1});
        vecs.push_back('{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1});
        vecs.push_back('{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000, 1});
        vecs.push_back('{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 34});
        vecs.push_back('{3'd7, 32'd100,        32'd7,         32'd2,         34});
        vecs.push_back('{3'd4, 32'd5,          32'd0,         32'hFFFF_FFFF, 1});
        vecs.push_back('{3'd6, 32'hFFFF_FFFB,  32'd0,         32'hFFFF_FFFB, 1});

        foreach (vecs[i]) begin
            do_op(vecs[i].f, vecs[i].a, vecs[i].b, res, lat, busy1);
            chk($sformatf("vec%0d result", i), res, vecs[i].exp);
            chk($sformatf("vec%0d latency", i), 32'(lat), 32'(vecs[i].lat));
            chk($sformatf("vec%0d busy", i), 32'(busy1), 32'(vecs[i].lat != 1));
            @(negedge CLK);
            chk($sformatf("vec%0d done pulse", i), 32'(DONE), 32'd0);
        end

        // START while busy is ignored; START during DONE waits one cycle.
        @(negedge CLK);
        START = 1'b1; A = 32'd1000; B = 32'd7; MDU_FUN = 3'd4;
        @(negedge CLK);
        START = 1'b0;
        lat = -1;
        for (int k = 1; k <= 60; k++) begin
            if (DONE) begin
                lat = k;
                break;
            end
            if (k == 4) begin START = 1'b1; A = 32'd5; B = 32'd1; MDU_FUN = 3'd0; end
            if (k == 5) START = 1'b0;
            @(negedge CLK);
        end
        chk("ignore latency", 32'(lat), 32'd34);
        chk("ignore result", RESULT, 32'd142);
        START = 1'b1; A = 32'h1234; B = 32'd0; MDU_FUN = 3'd5;
        @(negedge CLK);
        chk("start on done ignored", 32'(DONE), 32'd0);
        @(negedge CLK);
        START = 1'b0;
        chk("start after done accepted", 32'(DONE), 32'd1);
        chk("start after done result", RESULT, 32'hFFFF_FFFF);

        // Reset mid-operation aborts without DONE.
        @(negedge CLK);
        START = 1'b1; A = 32'd3; B = 32'd5; MDU_FUN = 3'd0;
        @(negedge CLK);
        START = 1'b0;
        repeat (8) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        chk("abort BUSY", 32'(BUSY), 32'd0);
        chk("abort DONE", 32'(DONE), 32'd0);
        chk("abort RESULT", RESULT, 32'd0);
        seen = 0;
        repeat (40) begin
            @(negedge CLK);
            if (DONE) seen++;
        end
        chk("abort no DONE", 32'(seen), 32'd0);

        for (int i = 0; i < 150; i++) begin
            logic [2:0]  f;
            logic [31:0] a, b;
            int          sel;
            f   = 3'($urandom_range(0, 7));
            a   = $urandom;
            b   = $urandom;
            sel = $urandom_range(0, 7);
            if (sel == 0) b = 32'd0;
            else if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            else if (sel == 2) a = 32'd0;
            else if (sel == 3) b = 32'($urandom_range(1, 16));
            do_op(f, a, b, res, lat, busy1);
            chk($sformatf("rand%0d f=%0d a=%h b=%h result", i, f, a, b), res, model(f, a, b));
            chk($sformatf("rand%0d latency", i), 32'(lat), 32'(model_lat(f, a, b)));
        end

        chk("BUSY and DONE overlap cycles", 32'(overlap), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
